bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter and sequencer for the memory-mapped data bus serving DM (0x0000_0000–0x0000_2FFF), timer0 (0x0000_7F00–0x0000_7F0B) and timer1 (0x0000_7F10–0x0000_7F1B). It accepts load/store requests from the CPU data port (master 0) and the DMA/debug port (master 1). It grants one request at a time by round-robin, decodes the target device, and drives a single-outstanding req/ready transaction to that device. It returns read data or an error to the owning master. It sits between the memory-stage byte-lane logic and the devices, in place of a direct CPU-to-bridge connection.

## Interface
- TIMEOUT, 15: maximum ACCESS cycles waiting for dev_ready before the transaction errors; must be ≥1.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req / m1_req  in  1  master request; held stable with its fields until the matching gnt.
- m0_addr / m1_addr  in  32  byte address.
- m0_we / m1_we  in  1  1 = store, 0 = load.
- m0_byteen / m1_byteen  in  4  store lane enables (already lane-shifted); ignored on loads.
- m0_wdata / m1_wdata  in  32  store data (already lane-shifted).
- m0_gnt / m1_gnt  out  1  request accepted this cycle.
- m0_rvalid / m1_rvalid  out  1  one-cycle response pulse.
- m0_rdata / m1_rdata  out  32  load data; valid with rvalid; 0 on stores or errors.
- m0_err / m1_err  out  1  error flag; valid with rvalid.
- dev_sel  out  3  one-hot target: bit0 DM, bit1 timer0, bit2 timer1.
- dev_req  out  1  device access strobe.
- dev_addr, dev_wdata  out  32  latched address and data.
- dev_we  out  1  latched write flag.
- dev_byteen  out  4  latched byte enables; 4'b0000 on loads.
- dev_ready  in  1  device completes the access in this cycle.
- dev_rdata  in  32  read data from the selected device (muxed externally by dev_sel).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick a winner: the only requester, or on a tie the master not in last_grant.
  - Assert the winner's gnt combinationally in that cycle.
  - At the edge, latch addr, we, byteen, wdata and the owner, and set last_grant = owner.
  - A mapped address goes to ACCESS. An unmapped address or an illegal access goes to RESP with err pending.
- Illegal access: a store to a timer with byteen ≠ 4'b1111, or any store to 0x7F08 or 0x7F18 (count registers are read-only).
- ACCESS: dev_req=1, and dev_sel/dev_* reflect the latched request.
  - dev_ready=1 at an edge: capture dev_rdata (only on a load), err=0, go to RESP.
  - Otherwise the timeout counter increments. When the count reaches TIMEOUT without dev_ready, go to RESP with err=1 and rdata=0.
- RESP: the owner's rvalid=1 for exactly one cycle, with rdata and err. Then go to IDLE. No gnt is issued in RESP.
- The non-owner's rvalid, gnt and err stay 0 throughout.
- All device outputs are 0 outside ACCESS.

## Timing
- Reset (asynchronous, while reset=0): state=IDLE, last_grant=1 (master 0 wins the first tie), timeout counter=0, all outputs 0.
- A reset asserted mid-transaction aborts it silently: no rvalid, dev_req drops immediately.
- Best-case latency: gnt in cycle N, ACCESS in N+1 with dev_ready=1, rvalid in N+2.
- Throughput: one transaction per 3 cycles at best.
- Error path without a device access: gnt in N, rvalid/err in N+1.
- Timeout: the device never answers → rvalid/err in cycle N+1+TIMEOUT. dev_req is high for exactly TIMEOUT cycles.
- The counter clears when entering ACCESS. Its width is $clog2(TIMEOUT+1); there is no wrap, because it stops at TIMEOUT.
- A request arriving during ACCESS or RESP waits, with no loss. It is granted on the first IDLE cycle.
- Back-to-back requests from both masters alternate 0,1,0,1…

## Structure
- Shared package (bus_pkg) holds:
  - address map bounds: DM_BASE/DM_LAST, T0_BASE/T0_LAST, T1_BASE/T1_LAST, T0_COUNT=0x7F08, T1_COUNT=0x7F18;
  - the FSM state enum;
  - the dev_sel one-hot encodings.
- Sub-module addr_decode (combinational): addr, we, byteen → dev_sel, mapped, illegal. It is reused by the exception logic.

## Test plan
- After reset, m0 loads 0x0000_0004 while dev_ready is held high with dev_rdata=0x1234_5678 → m0_gnt in cycle 0, dev_sel=3'b001 in cycle 1, m0_rvalid, m0_rdata=0x1234_5678 and m0_err=0 in cycle 2.
- m0 and m1 both request continuously with ready=1 → grant order m0,m1,m0,m1; each master sees rvalid every 6 cycles.
- m1 stores 0xDEAD_BEEF to 0x7F04 with byteen=1111 → dev_sel=3'b010, dev_we=1, dev_byteen=1111. A store to 0x7F08 → no dev_req, m1_err=1 one cycle after gnt.
- m0 loads 0x0000_4000 (unmapped) → no dev_req, m0_rvalid=1, m0_err=1, m0_rdata=0.
- dev_ready held low, TIMEOUT=15 → dev_req high for 15 cycles, then m0_rvalid=1, m0_err=1. The next request proceeds normally.
- reset pulsed low during ACCESS → dev_req=0 immediately, no rvalid. After release, an m0/m1 tie grants m0.

Source files
------------

// File: rtl/bus_pkg.sv
// ----------------------------------------------------------------------------
// bus_pkg
// Shared address map, FSM state encoding and device-select codes for the
// two-master data-bus arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bus_pkg;

  // Address map (inclusive byte bounds)
  localparam logic [31:0] DM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DM_LAST  = 32'h0000_2FFF;
  localparam logic [31:0] T0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] T0_LAST  = 32'h0000_7F0B;
  localparam logic [31:0] T1_BASE  = 32'h0000_7F10;
  localparam logic [31:0] T1_LAST  = 32'h0000_7F1B;

  // Read-only timer count registers
  localparam logic [31:0] T0_COUNT = 32'h0000_7F08;
  localparam logic [31:0] T1_COUNT = 32'h0000_7F18;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // One-hot device selects
  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_DM   = 3'b001;
  localparam logic [2:0] SEL_T0   = 3'b010;
  localparam logic [2:0] SEL_T1   = 3'b100;

  // Inclusive range test written as an offset compare so a zero base does not
  // degenerate into an always-true comparison.
  function automatic logic in_range(input logic [31:0] a,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    in_range = ((a - lo) <= (hi - lo));
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// bus_arbiter_if
// Bundles both master request/response ports and the device-side access port.
// The slave modport is the arbiter's view; the master modport is the view of
// the agents around it (masters and devices).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bus_arbiter_if;

  // Master 0 (CPU data port)
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_we;
  logic [3:0]  m0_byteen;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;

  // Master 1 (DMA/debug port)
  logic        m1_req;
  logic [31:0] m1_addr;
  logic        m1_we;
  logic [3:0]  m1_byteen;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;

  // Device side
  logic [2:0]  dev_sel;
  logic        dev_req;
  logic [31:0] dev_addr;
  logic [31:0] dev_wdata;
  logic        dev_we;
  logic [3:0]  dev_byteen;
  logic        dev_ready;
  logic [31:0] dev_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_we, m0_byteen, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_addr, m1_we, m1_byteen, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output dev_sel, dev_req, dev_addr, dev_wdata, dev_we, dev_byteen,
    input  dev_ready, dev_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_we, m0_byteen, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_addr, m1_we, m1_byteen, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  dev_sel, dev_req, dev_addr, dev_wdata, dev_we, dev_byteen,
    output dev_ready, dev_rdata
  );

endinterface

`default_nettype wire

// File: rtl/addr_decode.sv
// ----------------------------------------------------------------------------
// addr_decode
// Combinational target decode: one-hot device select, mapped flag and
// illegal-access flag for a single request.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module addr_decode
  import bus_pkg::*;
(
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  output logic [2:0]  sel,
  output logic        mapped,
  output logic        illegal
);

  logic hit_dm;
  logic hit_t0;
  logic hit_t1;
  logic hit_count;

  // Range decode and access-legality check
  always_comb begin
    hit_dm  = in_range(addr, DM_BASE, DM_LAST);
    hit_t0  = in_range(addr, T0_BASE, T0_LAST);
    hit_t1  = in_range(addr, T1_BASE, T1_LAST);
    // Count registers occupy a full word; match on the word address.
    hit_count = (addr[31:2] == T0_COUNT[31:2]) || (addr[31:2] == T1_COUNT[31:2]);

    sel = SEL_NONE;
    if (hit_dm) begin
      sel = SEL_DM;
    end else if (hit_t0) begin
      sel = SEL_T0;
    end else if (hit_t1) begin
      sel = SEL_T1;
    end

    mapped  = hit_dm | hit_t0 | hit_t1;
    // Timers accept only full-word stores and their count registers are read-only.
    illegal = we && ((((hit_t0 || hit_t1) && (byteen != 4'b1111))) || hit_count);
  end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
// Two-master round-robin arbiter and single-outstanding sequencer for the
// DM / timer0 / timer1 data bus, with device timeout and error return.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 15
)
(
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_next;

  logic          any_req;
  logic          winner;
  logic [31:0]   win_addr;
  logic          win_we;
  logic [3:0]    win_byteen;
  logic [31:0]   win_wdata;

  logic [2:0]    dec_sel;
  logic          dec_mapped;
  logic          dec_illegal;

  logic          last_grant;
  logic          owner;
  logic [31:0]   addr_q;
  logic          we_q;
  logic [3:0]    byteen_q;
  logic [31:0]   wdata_q;
  logic [2:0]    sel_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic [CW-1:0] cnt;
  logic          timeout_hit;

  // Round-robin pick and mux of the winner's request fields
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      winner = ~last_grant;
    end else begin
      winner = bus.m1_req;
    end
    win_addr   = winner ? bus.m1_addr   : bus.m0_addr;
    win_we     = winner ? bus.m1_we     : bus.m0_we;
    win_byteen = winner ? bus.m1_byteen : bus.m0_byteen;
    win_wdata  = winner ? bus.m1_wdata  : bus.m0_wdata;
    timeout_hit = (cnt == CNT_LAST);
  end

  addr_decode u_decode (
    .addr    (win_addr),
    .we      (win_we),
    .byteen  (win_byteen),
    .sel     (dec_sel),
    .mapped  (dec_mapped),
    .illegal (dec_illegal)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_next = (dec_mapped && !dec_illegal) ? ST_ACCESS : ST_RESP;
        end
      end
      ST_ACCESS: begin
        if (bus.dev_ready || timeout_hit) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request latch, response capture and timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      byteen_q   <= '0;
      wdata_q    <= '0;
      sel_q      <= SEL_NONE;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner      <= winner;
            last_grant <= winner;
            addr_q     <= win_addr;
            we_q       <= win_we;
            byteen_q   <= win_we ? win_byteen : 4'b0000;
            wdata_q    <= win_wdata;
            sel_q      <= dec_sel;
            err_q      <= ~(dec_mapped & ~dec_illegal);
            rdata_q    <= '0;
            cnt        <= '0;
          end
        end
        ST_ACCESS: begin
          if (bus.dev_ready) begin
            rdata_q <= we_q ? 32'h0 : bus.dev_rdata;
            err_q   <= 1'b0;
          end else begin
            // Leaving ACCESS on the timeout edge keeps the count from passing TIMEOUT.
            cnt <= cnt + 1'b1;
            if (timeout_hit) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs: grant in IDLE, device port in ACCESS, response in RESP
  always_comb begin
    bus.m0_gnt     = 1'b0;
    bus.m1_gnt     = 1'b0;
    bus.m0_rvalid  = 1'b0;
    bus.m1_rvalid  = 1'b0;
    bus.m0_rdata   = '0;
    bus.m1_rdata   = '0;
    bus.m0_err     = 1'b0;
    bus.m1_err     = 1'b0;
    bus.dev_sel    = SEL_NONE;
    bus.dev_req    = 1'b0;
    bus.dev_addr   = '0;
    bus.dev_wdata  = '0;
    bus.dev_we     = 1'b0;
    bus.dev_byteen = '0;

    // Grant is combinational from the request, so hold it off while reset is low.
    if ((state == ST_IDLE) && any_req && reset) begin
      bus.m0_gnt = ~winner;
      bus.m1_gnt = winner;
    end

    if (state == ST_ACCESS) begin
      bus.dev_req    = 1'b1;
      bus.dev_sel    = sel_q;
      bus.dev_addr   = addr_q;
      bus.dev_wdata  = wdata_q;
      bus.dev_we     = we_q;
      bus.dev_byteen = byteen_q;
    end

    if (state == ST_RESP) begin
      if (owner) begin
        bus.m1_rvalid = 1'b1;
        bus.m1_rdata  = rdata_q;
        bus.m1_err    = err_q;
      end else begin
        bus.m0_rvalid = 1'b1;
        bus.m0_rdata  = rdata_q;
        bus.m0_err    = err_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter. Expected responses are queued when a
// request is granted and compared when the owner's rvalid pulses.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bus_arbiter;

  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_arbiter_if bus ();

  bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        mst;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  rsp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  task automatic drive(input int m, input logic req, input logic [31:0] a,
                       input logic we, input logic [3:0] be, input logic [31:0] wd);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_addr = a; bus.m0_we = we; bus.m0_byteen = be; bus.m0_wdata = wd;
    end else begin
      bus.m1_req = req; bus.m1_addr = a; bus.m1_we = we; bus.m1_byteen = be; bus.m1_wdata = wd;
    end
  endtask

  task automatic push(input logic m, input logic [31:0] d, input logic e);
    sb.push_back('{mst: m, rdata: d, err: e});
  endtask

  // Response scoreboard: every rvalid must match the oldest queued expectation
  always @(negedge clk) begin
    if (bus.m0_rvalid || bus.m1_rvalid) begin
      check1("rvalid_one_hot", bus.m0_rvalid & bus.m1_rvalid, 1'b0);
      check1("rvalid_expected", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check1("rsp_master", bus.m1_rvalid, mon_e.mst);
        check("rsp_rdata", mon_e.mst ? bus.m1_rdata : bus.m0_rdata, mon_e.rdata);
        check1("rsp_err", mon_e.mst ? bus.m1_err : bus.m0_err, mon_e.err);
        check1("rsp_other_err", mon_e.mst ? bus.m0_err : bus.m1_err, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int   grants;
  int   last_cyc;
  logic exp_win;
  int   n_req;
  logic done;

  initial begin
    reset = 1'b0;
    drive(0, 1'b1, 32'h0000_0004, 1'b0, 4'b0000, 32'h0);
    drive(1, 1'b1, 32'h0000_0008, 1'b0, 4'b0000, 32'h0);
    bus.dev_ready = 1'b1;
    bus.dev_rdata = 32'h1234_5678;

    // Reset: everything quiet even with both masters requesting
    step; step;
    at_neg;
    check1("rst_m0_gnt", bus.m0_gnt, 1'b0);
    check1("rst_m1_gnt", bus.m1_gnt, 1'b0);
    check1("rst_dev_req", bus.dev_req, 1'b0);
    check("rst_dev_sel", {29'b0, bus.dev_sel}, 32'h0);
    check1("rst_m0_rvalid", bus.m0_rvalid, 1'b0);

    // Best-case load by m0
    step;
    reset = 1'b1;
    drive(1, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
    push(1'b0, 32'h1234_5678, 1'b0);
    at_neg;
    check1("t1_m0_gnt", bus.m0_gnt, 1'b1);
    check1("t1_m1_gnt", bus.m1_gnt, 1'b0);
    check1("t1_no_dev_req_idle", bus.dev_req, 1'b0);
    step;
    drive(0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
    at_neg;
    check1("t1_dev_req", bus.dev_req, 1'b1);
    check("t1_dev_sel", {29'b0, bus.dev_sel}, 32'h1);
    check("t1_dev_addr", bus.dev_addr, 32'h0000_0004);
    check1("t1_dev_we", bus.dev_we, 1'b0);
    check("t1_dev_byteen", {28'b0, bus.dev_byteen}, 32'h0);
    step;
    at_neg;
    check1("t1_resp_no_dev_req", bus.dev_req, 1'b0);
    step;

    // Continuous requests from both: m0 was granted last, so m1 wins first
    bus.dev_rdata = 32'hA5A5_0001;
    drive(0, 1'b1, 32'h0000_0010, 1'b0, 4'b0000, 32'h0);
    drive(1, 1'b1, 32'h0000_0020, 1'b0, 4'b0000, 32'h0);
    grants = 0; last_cyc = -1; exp_win = 1'b1;
    for (int i = 0; i < 30 && grants < 4; i++) begin
      at_neg;
      if (bus.m0_gnt || bus.m1_gnt) begin
        check1("rr_order", bus.m1_gnt, exp_win);
        check1("rr_single_gnt", bus.m0_gnt & bus.m1_gnt, 1'b0);
        if (last_cyc >= 0) check("rr_gap", cyc - last_cyc, 32'd3);
        last_cyc = cyc;
        push(exp_win, 32'hA5A5_0001, 1'b0);
        exp_win = ~exp_win;
        grants++;
      end
      step;
    end
    check("rr_grants", grants, 32'd4);
    drive(0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
    drive(1, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
    step; step;

    // m1 full-word store to timer0
    drive(1, 1'b1, 32'h0000_7F04, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    push(1'b1, 32'h0, 1'b0);
    at_neg;
    check1("t3_m1_gnt", bus.m1_gnt, 1'b1);
    check1("t3_m0_gnt", bus.m0_gnt, 1'b0);
    step;
    drive(1, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
    at_neg;
    check("t3_dev_sel", {29'b0, bus.dev_sel}, 32'h2);
    check1("t3_dev_we", bus.dev_we, 1'b1);
    check("t3_dev_byteen", {28'b0, bus.dev_byteen}, 32'hF);
    check("t3_dev_wdata", bus.dev_wdata, 32'hDEAD_BEEF);
    check("t3_dev_addr", bus.dev_addr, 32'h0000_7F04);
    step; step;

    // m1 store to read-only count register: error one cycle after gnt
    drive(1, 1'b1, 32'h0000_7F08, 1'b1, 4'b1111, 32'h1);
    push(1'b1, 32'h0, 1'b1);
    at_neg;
    check1("t3b_m1_gnt", bus.m1_gnt, 1'b1);
    step;
    drive(1, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
    at_neg;
    check1("t3b_no_dev_req", bus.dev_req, 1'b0);
    step;

    // m0 partial store to timer1: illegal
    drive(0, 1'b1, 32'h0000_7F14, 1'b1, 4'b0011, 32'h55);
    push(1'b0, 32'h0, 1'b1);
    at_neg;
    check1("t3c_m0_gnt", bus.m0_gnt, 1'b1);
    step;
    drive(0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
    at_neg;
    check1("t3c_no_dev_req", bus.dev_req, 1'b0);
    step;

    // m0 load from unmapped 0x4000
    drive(0, 1'b1, 32'h0000_4000, 1'b0, 4'b0000, 32'h0);
    push(1'b0, 32'h0, 1'b1);
    at_neg;
    check1("t4_m0_gnt", bus.m0_gnt, 1'b1);
    step;
    drive(0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
    at_neg;
    check1("t4_no_dev_req", bus.dev_req, 1'b0);
    step;

    // Boundaries: last DM word is mapped, just past timer1 is not
    bus.dev_rdata = 32'h0BAD_F00D;
    drive(1, 1'b1, 32'h0000_2FFC, 1'b0, 4'b0000, 32'h0);
    push(1'b1, 32'h0BAD_F00D, 1'b0);
    at_neg;
    check1("t4b_m1_gnt", bus.m1_gnt, 1'b1);
    step;
    drive(1, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
    at_neg;
    check("t4b_dev_sel", {29'b0, bus.dev_sel}, 32'h1);
    step; step;
    drive(1, 1'b1, 32'h0000_7F1C, 1'b0, 4'b0000, 32'h0);
    push(1'b1, 32'h0, 1'b1);
    at_neg;
    check1("t4c_m1_gnt", bus.m1_gnt, 1'b1);
    step;
    drive(1, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
    at_neg;
    check1("t4c_no_dev_req", bus.dev_req, 1'b0);
    step;

    // Timeout: device never answers
    bus.dev_ready = 1'b0;
    bus.dev_rdata = 32'hFFFF_FFFF;
    drive(0, 1'b1, 32'h0000_0100, 1'b0, 4'b0000, 32'h0);
    push(1'b0, 32'h0, 1'b1);
    at_neg;
    check1("t5_m0_gnt", bus.m0_gnt, 1'b1);
    step;
    drive(0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
    n_req = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      at_neg;
      if (bus.dev_req) n_req++;
      if (bus.m0_rvalid) done = 1'b1;
      step;
    end
    check1("t5_rvalid_seen", done, 1'b1);
    check("t5_dev_req_cycles", n_req, TIMEOUT);

    // Next request after a timeout proceeds normally
    bus.dev_ready = 1'b1;
    bus.dev_rdata = 32'hCAFE_F00D;
    drive(0, 1'b1, 32'h0000_0200, 1'b0, 4'b0000, 32'h0);
    push(1'b0, 32'hCAFE_F00D, 1'b0);
    at_neg;
    check1("t5b_m0_gnt", bus.m0_gnt, 1'b1);
    step;
    drive(0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
    at_neg;
    check1("t5b_dev_req", bus.dev_req, 1'b1);
    step; step;

    // Reset during ACCESS aborts silently; no response is queued for it
    bus.dev_ready = 1'b0;
    drive(1, 1'b1, 32'h0000_0008, 1'b0, 4'b0000, 32'h0);
    at_neg;
    check1("t6_m1_gnt", bus.m1_gnt, 1'b1);
    step;
    drive(1, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
    at_neg;
    check1("t6_dev_req_before", bus.dev_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check1("t6_dev_req_drop", bus.dev_req, 1'b0);
    check("t6_dev_sel_drop", {29'b0, bus.dev_sel}, 32'h0);
    check1("t6_m1_rvalid", bus.m1_rvalid, 1'b0);
    drive(0, 1'b1, 32'h0000_0030, 1'b0, 4'b0000, 32'h0);
    drive(1, 1'b1, 32'h0000_0034, 1'b0, 4'b0000, 32'h0);
    step;
    at_neg;
    check1("t6_rst_m0_gnt", bus.m0_gnt, 1'b0);
    check1("t6_rst_m1_gnt", bus.m1_gnt, 1'b0);
    step;
    reset = 1'b1;
    bus.dev_ready = 1'b1;
    bus.dev_rdata = 32'h600D_0000;
    push(1'b0, 32'h600D_0000, 1'b0);
    at_neg;
    check1("t6_tie_m0_gnt", bus.m0_gnt, 1'b1);
    check1("t6_tie_m1_gnt", bus.m1_gnt, 1'b0);
    step;
    drive(0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
    drive(1, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0);
    step; step; step;
    at_neg;
    check("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
